// File: rtl/updown_counter_n.sv
// Modulo-N up/down counter with synchronous load, a combinational terminal count and a registered limit pulse.
// Define UDC_STICKY_FLAG_EN to add sticky overflow/underflow flags with a flag_clr input.
module updown_counter_n #(
  parameter int unsigned     WIDTH    = 3,
  parameter longint unsigned MODULUS  = 8,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef UDC_STICKY_FLAG_EN
  ,
  input  logic             flag_clr,
  output logic             ovf,
  output logic             unf
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic             at_max;
  logic             at_zero;
  logic             limit_evt;
  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] count_nxt;

  assign at_max    = (count == MAX_VAL);
  assign at_zero   = (count == '0);
  assign tc        = en & (up_down ? at_max : at_zero);
  // A load overrides the step, so a terminal count under load is not a limit event.
  assign limit_evt = tc & ~load;
  assign load_sat  = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_sat;
    end else if (en) begin
      if (up_down) begin
        if (at_max) count_nxt = SATURATE ? MAX_VAL : '0;
        else        count_nxt = count + WIDTH'(1);
      end else begin
        if (at_zero) count_nxt = SATURATE ? '0 : MAX_VAL;
        else         count_nxt = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= limit_evt;
    end
  end

`ifdef UDC_STICKY_FLAG_EN
  // A limit event wins over flag_clr at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (limit_evt && up_down)       ovf <= 1'b1;
      else if (flag_clr)              ovf <= 1'b0;
      if (limit_evt && !up_down)      unf <= 1'b1;
      else if (flag_clr)              unf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench for updown_counter_n: default, MODULUS=6 wrapping and MODULUS=6 saturating instances share stimulus.
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [2:0] load_val = '0;

  logic [2:0] count_a, count_b, count_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;
`ifdef UDC_STICKY_FLAG_EN
  logic       flag_clr = 1'b0;
  logic       ovf_a, ovf_b, ovf_c;
  logic       unf_a, unf_b, unf_c;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  updown_counter_n dut_a (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .count(count_a), .tc(tc_a), .wrap(wrap_a)
`ifdef UDC_STICKY_FLAG_EN
    , .flag_clr(flag_clr), .ovf(ovf_a), .unf(unf_a)
`endif
  );

  updown_counter_n #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .count(count_b), .tc(tc_b), .wrap(wrap_b)
`ifdef UDC_STICKY_FLAG_EN
    , .flag_clr(flag_clr), .ovf(ovf_b), .unf(unf_b)
`endif
  );

  updown_counter_n #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .count(count_c), .tc(tc_c), .wrap(wrap_c)
`ifdef UDC_STICKY_FLAG_EN
    , .flag_clr(flag_clr), .ovf(ovf_c), .unf(unf_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs are changed and outputs sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int exp_cnt;

    // Reset state
    step();
    rst = 1'b1;
    #1;
    chk("rst_count_a", 32'(count_a), 0);
    chk("rst_wrap_a", 32'(wrap_a), 0);
    step();
    rst = 1'b0;

    // Default instance counting up through the wrap
    en = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("up_tc_a", 32'(tc_a), 32'((i % 8) == 7));
      step();
      exp_cnt = (i + 1) % 8;
      chk("up_count_a", 32'(count_a), 32'(exp_cnt));
      chk("up_wrap_a", 32'(wrap_a), 32'(i == 7));
    end
`ifdef UDC_STICKY_FLAG_EN
    chk("up_ovf_a", 32'(ovf_a), 1);
    chk("up_unf_a", 32'(unf_a), 0);
`endif

    // MODULUS=6 wrapping, counting down from 0
    rst_pulse();
    up_down = 1'b0;
    step();
    chk("dn_count_b0", 32'(count_b), 5);
    chk("dn_wrap_b0", 32'(wrap_b), 1);
`ifdef UDC_STICKY_FLAG_EN
    chk("dn_unf_b0", 32'(unf_b), 1);
`endif
    step();
    chk("dn_count_b1", 32'(count_b), 4);
    chk("dn_wrap_b1", 32'(wrap_b), 0);
    step();
    chk("dn_count_b2", 32'(count_b), 3);
`ifdef UDC_STICKY_FLAG_EN
    chk("dn_unf_hold_b", 32'(unf_b), 1);
    en = 1'b0; flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("dn_unf_clr_b", 32'(unf_b), 0);
    chk("dn_count_hold_b", 32'(count_b), 3);
`endif

    // Out-of-range load clamps; saturating instance holds at the top and pulses wrap
    en = 1'b0; load = 1'b1; load_val = 3'd7;
    step();
    load = 1'b0;
    chk("ld_clamp_c", 32'(count_c), 5);
    chk("ld_noclamp_a", 32'(count_a), 7);
    en = 1'b1; up_down = 1'b1;
    #1;
    chk("sat_tc_c", 32'(tc_c), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_count_c", 32'(count_c), 5);
      chk("sat_wrap_c", 32'(wrap_c), 1);
      chk("after_ld_count_a", 32'(count_a), 32'(i));
    end

    // Load beats enable at count=3
    en = 1'b0; load = 1'b1; load_val = 3'd3;
    step();
    chk("ld3_count_a", 32'(count_a), 3);
    en = 1'b1; up_down = 1'b0; load_val = 3'd6;
    step();
    chk("ld_pri_count_a", 32'(count_a), 6);
    chk("ld_pri_wrap_a", 32'(wrap_a), 0);

    // Load at terminal count suppresses the wrap pulse
    en = 1'b0; load_val = 3'd0;
    step();
    en = 1'b1; up_down = 1'b0; load_val = 3'd6;
    #1;
    chk("ld_tc_a", 32'(tc_a), 1);
    step();
    load = 1'b0;
    chk("ld_tc_count_a", 32'(count_a), 6);
    chk("ld_tc_wrap_a", 32'(wrap_a), 0);

    // Asynchronous reset mid-count
    en = 1'b0; load = 1'b1; load_val = 3'd4;
    step();
    load = 1'b0; en = 1'b1; up_down = 1'b1;
    step();
    chk("pre_rst_count_a", 32'(count_a), 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count_a", 32'(count_a), 0);
    #1 rst = 1'b0;
    step();
    chk("post_rst_count_a", 32'(count_a), 1);

    // Direction toggling every edge from 2
    en = 1'b0; load = 1'b1; load_val = 3'd2;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_down = ((i % 2) == 0);
      #1;
      chk("tog_tc_a", 32'(tc_a), 0);
      step();
      chk("tog_count_a", 32'(count_a), ((i % 2) == 0) ? 3 : 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 3, counter width in bits (legal range 1..32).
REQ-002 SHALL have parameter MODULUS, default 8, count range 0..MODULUS-1 (legal range 2..2**WIDTH).
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-004 SHALL have port clk  input  1  single clock, all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up_down  input  1  direction: 1 = count up, 0 = count down.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value to load.
REQ-010 SHALL have port count  output  WIDTH  registered counter value.
REQ-011 SHALL have port tc  output  1  combinational terminal count.
REQ-012 SHALL have port wrap  output  1  registered one-cycle limit-event pulse.
REQ-013 SHALL have, only when UDC_STICKY_FLAG_EN is defined, ports flag_clr (input, 1, clears flags), ovf (output, 1, sticky overflow) and unf (output, 1, sticky underflow).

Function
REQ-014 SHALL apply priority, per clock edge: rst > load > en > hold.
REQ-015 SHALL, on load=1, set count to load_val, or to MODULUS-1 if load_val >= MODULUS; en and up_down are ignored that cycle.
REQ-016 SHALL, with en=1 and load=0, increment count by 1 when up_down=1 and decrement it by 1 when up_down=0.
REQ-017 SHALL hold count when en=0 and load=0.
REQ-018 SHALL, when SATURATE=0, wrap MODULUS-1 -> 0 counting up and 0 -> MODULUS-1 counting down.
REQ-019 SHALL, when SATURATE=1, hold count at MODULUS-1 counting up and at 0 counting down.
REQ-020 SHALL drive tc=1 exactly when en=1 and either (up_down=1 and count=MODULUS-1) or (up_down=0 and count=0), combinationally from current inputs and state.
REQ-021 SHALL assert wrap for exactly the one cycle following any edge at which tc=1 and load=0, in both SATURATE modes.
REQ-022 SHALL produce count changes with one-cycle latency from the en, load or up_down sample edge; there are no multi-cycle operations.
REQ-023 SHALL treat an up_down toggle as effective on the next edge, with no dead cycle.
REQ-024 SHALL never present a count value >= MODULUS on count.

Reset
REQ-025 SHALL, while rst=1, immediately force count=0, wrap=0 and, when compiled in, ovf=0 and unf=0, independent of clk.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst deasserts; a reset mid-count discards the in-progress value.

Configuration
REQ-027 SHALL, with UDC_STICKY_FLAG_EN defined, set ovf on an up-direction limit event and unf on a down-direction limit event (same condition as wrap); both remain set until flag_clr=1 or rst.
REQ-028 SHALL give a limit event priority over flag_clr when both occur at the same edge, so the flag stays set.
REQ-029 SHALL, without UDC_STICKY_FLAG_EN defined, omit flag_clr, ovf and unf entirely, leaving all other behaviour identical.

Verification
REQ-030 SHALL cover: defaults, rst pulse, then en=1 up_down=1 for 9 edges -> count 1..7,0,1; tc=1 while count=7; wrap=1 on the cycle count=0.
REQ-031 SHALL cover: MODULUS=6 SATURATE=0, en=1 up_down=0 from 0 -> count 5,4,3; with ovf/unf compiled in, unf=1 after the first edge, cleared by flag_clr.
REQ-032 SHALL cover: MODULUS=6 SATURATE=1, load_val=7 load=1 -> count=5; then en=1 up_down=1 for 3 edges -> count stays 5 and wrap pulses each cycle.
REQ-033 SHALL cover: defaults, count=3, load=1 load_val=6 en=1 up_down=0 on the same edge -> count=6, wrap=0.
REQ-034 SHALL cover: defaults, counting up at count=5, rst asserted between edges -> count=0 without a clock edge; the first edge after release with en=1 -> count=1.
REQ-035 SHALL cover: defaults, en=1 with up_down toggled every edge starting from count=2 and up_down=1 -> count 3,2,3,2, and tc never asserts.
